// File: rtl/rotary_step_ctrl.sv
// rotary_step_ctrl: one bounded up/down value step per rotary detent, with post-step lockout.
// Build option: define ROTARY_WRAP_EN to wrap at MIN_VAL/MAX_VAL instead of saturating.
module rotary_step_ctrl #(
    parameter int WIDTH   = 8,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 255,
    parameter int HOLDOFF = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             r_event,
    input  logic             r_dir,
    input  logic             clr,
    output logic [WIDTH-1:0] value,
    output logic             step_valid,
    output logic             step_dir,
    output logic             at_min,
    output logic             at_max
);
    localparam int             HW      = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
    localparam logic [WIDTH:0] MIN_X   = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH:0] MAX_X   = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] ONE_X   = (WIDTH+1)'(1);
    localparam logic [HW-1:0]  HOLD_LD = HW'(HOLDOFF);
    localparam logic [HW-1:0]  ONE_H   = HW'(1);

    typedef enum logic [1:0] {IDLE, HOLD, WAIT_LOW} state_t;

    state_t           state_q, state_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic [WIDTH-1:0] value_q, value_d;
    logic             ev_q;
    logic             step_valid_q, step_valid_d;
    logic             step_dir_q, step_dir_d;
    logic             at_min_q, at_min_d;
    logic             at_max_q, at_max_d;
    logic             rise, up_ovf, dn_unf;
    logic [WIDTH:0]   val_x, up_x, dn_x;
    logic [WIDTH-1:0] step_v;

    // Extra top bit lets over/underflow be seen before the bound compare.
    assign rise   = r_event & ~ev_q;
    assign val_x  = {1'b0, value_q};
    assign up_x   = val_x + ONE_X;
    assign dn_x   = val_x - ONE_X;
    assign up_ovf = up_x > MAX_X;
    assign dn_unf = dn_x[WIDTH] | (dn_x < MIN_X);
`ifdef ROTARY_WRAP_EN
    assign step_v = r_dir ? (up_ovf ? MIN_X[WIDTH-1:0] : up_x[WIDTH-1:0])
                          : (dn_unf ? MAX_X[WIDTH-1:0] : dn_x[WIDTH-1:0]);
`else
    assign step_v = r_dir ? (up_ovf ? MAX_X[WIDTH-1:0] : up_x[WIDTH-1:0])
                          : (dn_unf ? MIN_X[WIDTH-1:0] : dn_x[WIDTH-1:0]);
`endif

    // Next state: accept a detent in IDLE, then lock out and wait for the event level to drop.
    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        value_d      = value_q;
        step_valid_d = 1'b0;
        step_dir_d   = step_dir_q;
        case (state_q)
            IDLE: if (rise) begin
                value_d      = step_v;
                step_valid_d = 1'b1;
                step_dir_d   = r_dir;
                hcnt_d       = HOLD_LD;
                state_d      = (HOLDOFF == 0) ? WAIT_LOW : HOLD;
            end
            HOLD: begin
                hcnt_d = hcnt_q - ONE_H;
                if (hcnt_q == ONE_H) state_d = WAIT_LOW;
            end
            WAIT_LOW: if (!r_event) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Clear wins over a coincident step but the detent is still consumed by the FSM.
        if (clr) begin
            value_d      = MIN_X[WIDTH-1:0];
            step_valid_d = 1'b0;
            step_dir_d   = step_dir_q;
        end
        at_min_d = value_d == MIN_X[WIDTH-1:0];
        at_max_d = value_d == MAX_X[WIDTH-1:0];
    end

    // State registers; ev_q resets high so a level already high at release is not a rise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            hcnt_q       <= '0;
            value_q      <= MIN_X[WIDTH-1:0];
            ev_q         <= 1'b1;
            step_valid_q <= 1'b0;
            step_dir_q   <= 1'b0;
            at_min_q     <= 1'b1;
            at_max_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            value_q      <= value_d;
            ev_q         <= r_event;
            step_valid_q <= step_valid_d;
            step_dir_q   <= step_dir_d;
            at_min_q     <= at_min_d;
            at_max_q     <= at_max_d;
        end
    end

    assign value      = value_q;
    assign step_valid = step_valid_q;
    assign step_dir   = step_dir_q;
    assign at_min     = at_min_q;
    assign at_max     = at_max_q;
endmodule

// File: tb/tb_rotary_step_ctrl.sv
// tb_rotary_step_ctrl: scoreboard bench for two rotary_step_ctrl configurations.
module tb_rotary_step_ctrl;
`ifdef ROTARY_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  v;
        logic        d;
        logic        mn;
        logic        mx;
        logic [31:0] c;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ev_a = 1'b0, dir_a = 1'b0, clr_a = 1'b0;
    logic       ev_b = 1'b0, dir_b = 1'b0, clr_b = 1'b0;
    logic [7:0] val_a, val_b;
    logic       sv_a, sd_a, mn_a, mx_a;
    logic       sv_b, sd_b, mn_b, mx_b;
    exp_t       qa[$];
    exp_t       qb[$];
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rotary_step_ctrl u_a (
        .clk(clk), .rst_n(rst_n), .r_event(ev_a), .r_dir(dir_a), .clr(clr_a),
        .value(val_a), .step_valid(sv_a), .step_dir(sd_a), .at_min(mn_a), .at_max(mx_a)
    );

    rotary_step_ctrl #(.WIDTH(8), .MIN_VAL(2), .MAX_VAL(12), .HOLDOFF(0)) u_b (
        .clk(clk), .rst_n(rst_n), .r_event(ev_b), .r_dir(dir_b), .clr(clr_b),
        .value(val_b), .step_valid(sv_b), .step_dir(sd_b), .at_min(mn_b), .at_max(mx_b)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitors: every step_valid pulse must match the oldest expected step, including its cycle.
    always @(negedge clk) begin
        if (sv_a !== 1'b0) begin
            if (qa.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL a_unexpected_step: got step value %0d at cycle %0d, expected none", val_a, cyc);
            end else chk("a_step", 64'({val_a, sd_a, mn_a, mx_a, 32'(cyc)}), 64'(qa.pop_front()));
        end
    end

    always @(negedge clk) begin
        if (sv_b !== 1'b0) begin
            if (qb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL b_unexpected_step: got step value %0d at cycle %0d, expected none", val_b, cyc);
            end else chk("b_step", 64'({val_b, sd_b, mn_b, mx_b, 32'(cyc)}), 64'(qb.pop_front()));
        end
    end

    task automatic push_a(input logic [7:0] v, input logic d, input logic mn, input logic mx);
        qa.push_back({v, d, mn, mx, 32'(cyc + 1)});
    endtask

    task automatic push_b(input logic [7:0] v, input logic d, input logic mn, input logic mx);
        qb.push_back({v, d, mn, mx, 32'(cyc + 1)});
    endtask

    task automatic det_a(input logic d, input logic [7:0] v, input logic mn, input logic mx);
        ev_a = 1'b1;
        dir_a = d;
        push_a(v, d, mn, mx);
        tick();
        ev_a = 1'b0;
        tick(19);
    endtask

    task automatic det_b(input logic d, input logic [7:0] v, input logic mn, input logic mx);
        ev_b = 1'b1;
        dir_b = d;
        push_b(v, d, mn, mx);
        tick();
        ev_b = 1'b0;
        tick();
    endtask

    initial begin
        ev_a = 1'b1;
        tick(3);
        chk("a_rst_value", 64'(val_a), 64'd0);
        chk("a_rst_flags", 64'({sv_a, sd_a, mn_a, mx_a}), 64'b0010);
        chk("b_rst_value", 64'(val_b), 64'd2);
        chk("b_rst_flags", 64'({sv_b, sd_b, mn_b, mx_b}), 64'b0010);
        rst_n = 1'b1;
        tick(4);
        chk("a_held_high_no_step", 64'(val_a), 64'd0);
        ev_a = 1'b0;
        tick();
        ev_a = 1'b1;
        dir_a = 1'b1;
        push_a(8'd1, 1'b1, 1'b0, 1'b0);
        tick(5);
        ev_a = 1'b0;
        tick(19);
        chk("a_first_step_value", 64'(val_a), 64'd1);
        ev_a = 1'b1;
        push_a(8'd2, 1'b1, 1'b0, 1'b0);
        tick(2);
        for (int k = 0; k < 4; k++) begin
            ev_a = ~ev_a;
            tick(2);
        end
        ev_a = 1'b0;
        tick(25);
        chk("a_chatter_value", 64'(val_a), 64'd2);
        ev_a = 1'b1;
        push_a(8'd3, 1'b1, 1'b0, 1'b0);
        tick(30);
        ev_a = 1'b0;
        tick(3);
        chk("a_held_one_step", 64'(val_a), 64'd3);
        ev_a = 1'b1;
        dir_a = 1'b0;
        push_a(8'd2, 1'b0, 1'b0, 1'b0);
        tick();
        ev_a = 1'b0;
        tick(16);
        ev_a = 1'b1;
        tick();
        ev_a = 1'b0;
        tick();
        ev_a = 1'b1;
        dir_a = 1'b1;
        push_a(8'd3, 1'b1, 1'b0, 1'b0);
        tick();
        ev_a = 1'b0;
        tick(17);
        ev_a = 1'b1;
        dir_a = 1'b0;
        push_a(8'd2, 1'b0, 1'b0, 1'b0);
        tick();
        ev_a = 1'b0;
        tick(19);
        det_a(1'b1, 8'd3, 1'b0, 1'b0);
        det_a(1'b1, 8'd4, 1'b0, 1'b0);
        det_a(1'b1, 8'd5, 1'b0, 1'b0);
        ev_a = 1'b1;
        dir_a = 1'b1;
        clr_a = 1'b1;
        tick();
        chk("a_clr_value", 64'(val_a), 64'd0);
        chk("a_clr_flags", 64'({sv_a, mn_a, mx_a}), 64'b010);
        clr_a = 1'b0;
        ev_a = 1'b0;
        tick();
        ev_a = 1'b1;
        tick();
        ev_a = 1'b0;
        tick(25);
        chk("a_clr_hold_value", 64'(val_a), 64'd0);
        det_a(1'b1, 8'd1, 1'b0, 1'b0);
        det_a(1'b0, 8'd0, 1'b1, 1'b0);
        det_a(1'b0, WRAP ? 8'd255 : 8'd0, !WRAP, WRAP);
        ev_a = 1'b1;
        dir_a = 1'b1;
        push_a(WRAP ? 8'd0 : 8'd1, 1'b1, WRAP, 1'b0);
        tick();
        ev_a = 1'b0;
        tick(3);
        rst_n = 1'b0;
        tick();
        chk("a_midhold_rst_value", 64'(val_a), 64'd0);
        chk("a_midhold_rst_flags", 64'({sv_a, sd_a, mn_a, mx_a}), 64'b0010);
        rst_n = 1'b1;
        tick(2);
        det_a(1'b1, 8'd1, 1'b0, 1'b0);
        for (int v = 3; v <= 12; v++) det_b(1'b1, 8'(v), 1'b0, v == 12);
        det_b(1'b1, WRAP ? 8'd2 : 8'd12, WRAP, !WRAP);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        chk("b_clr_value", 64'({val_b, mn_b, mx_b}), 64'({8'd2, 2'b10}));
        det_b(1'b0, WRAP ? 8'd12 : 8'd2, !WRAP, WRAP);
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        tick();
        for (int v = 3; v <= 10; v++) det_b(1'b1, 8'(v), 1'b0, 1'b0);
        det_b(1'b0, 8'd9, 1'b0, 1'b0);
        det_b(1'b0, 8'd8, 1'b0, 1'b0);
        tick(3);
        chk("b_final_value", 64'(val_b), 64'd8);
        chk("a_queue_empty", 64'(qa.size()), 64'd0);
        chk("b_queue_empty", 64'(qb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
